// File: rtl/asic_bridge_pkg.sv
// asic_bridge_pkg: register sizes, init words and receiver state encoding
// shared by the bridge transmitter, the ASIC receiver and their benches.
package asic_bridge_pkg;
    localparam int SIZESRDYN_DEF  = 16;
    localparam int SIZESRSTAT_DEF = 88;
    localparam logic [15:0] DYN_INIT  = 16'hABC6;
    localparam logic [87:0] STAT_INIT = 88'h123456789ABCDEF1234567;
    typedef enum logic [1:0] {SHIFT_DYN, WAIT_STAT, SHIFT_STAT, DONE} rxState_t;
endpackage

// File: rtl/asic_sr_receiver_sync_bit.sv
// sync_bit: depth-configurable flop chain bringing one asynchronous bit into CLK.
module sync_bit #(
    parameter int STAGES = 2
) (
    input  logic CLK,
    input  logic RST_N,
    input  logic d,
    output logic q
);
    logic [STAGES-1:0] chain;
    always_ff @(posedge CLK) begin
        if (!RST_N) chain <= '0;
        else        chain <= {chain[STAGES-2:0], d};
    end
    assign q = chain[STAGES-1];
endmodule

// File: rtl/asic_sr_receiver.sv
// asic_sr_receiver: oversampling deserializer rebuilding the dynamic and static
// registers from the bridge's gated serial link, with frame error detection.
module asic_sr_receiver
    import asic_bridge_pkg::*;
#(
    parameter int SIZESRDYN      = SIZESRDYN_DEF,
    parameter int SIZESRSTAT     = SIZESRSTAT_DEF,
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic                  SCLK_in,
    input  logic                  SEL_in,
    input  logic                  MOSI_in,
    output logic [SIZESRDYN-1:0]  dyn_reg,
    output logic [SIZESRSTAT-1:0] stat_reg,
    output logic                  dyn_valid,
    output logic                  stat_valid,
    output logic                  frame_err,
    output logic                  busy
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic                  sclkSync, selSync, mosiSync, sclkPrev, sclkRise, toRun;
    logic [6:0]            cnt;
    logic [TW-1:0]         toCnt;
    logic [SIZESRDYN-1:0]  shDyn, dynNext;
    logic [SIZESRSTAT-1:0] shStat, statNext;
    rxState_t              state;

    sync_bit #(.STAGES(SYNC_STAGES)) uSyncSclk (.CLK(CLK), .RST_N(RST_N), .d(SCLK_in), .q(sclkSync));
    sync_bit #(.STAGES(SYNC_STAGES)) uSyncSel  (.CLK(CLK), .RST_N(RST_N), .d(SEL_in),  .q(selSync));
    sync_bit #(.STAGES(SYNC_STAGES)) uSyncMosi (.CLK(CLK), .RST_N(RST_N), .d(MOSI_in), .q(mosiSync));

    assign sclkRise = sclkSync & ~sclkPrev;
    assign dynNext  = {shDyn[SIZESRDYN-2:0], mosiSync};
    assign statNext = {shStat[SIZESRSTAT-2:0], mosiSync};
    assign toRun    = (cnt != '0) || (state == WAIT_STAT);
    assign busy     = (state == WAIT_STAT) || (state == SHIFT_STAT) || (state == SHIFT_DYN && cnt != '0);

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state      <= SHIFT_DYN;
            cnt        <= '0;
            toCnt      <= '0;
            sclkPrev   <= 1'b0;
            shDyn      <= '0;
            shStat     <= '0;
            dyn_reg    <= '0;
            stat_reg   <= '0;
            dyn_valid  <= 1'b0;
            stat_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            dyn_valid  <= 1'b0;
            stat_valid <= 1'b0;
            sclkPrev   <= sclkSync;
            toCnt      <= sclkRise ? '0 : (toRun ? toCnt + 1'b1 : toCnt);
            if (sclkRise) begin
                case (state)
                    SHIFT_DYN:
                        if (selSync) begin
                            shDyn <= dynNext;
                            if (cnt == 7'(SIZESRDYN - 1)) begin
                                dyn_reg   <= dynNext;
                                dyn_valid <= 1'b1;
                                cnt       <= '0;
                                state     <= WAIT_STAT;
                            end else begin
                                cnt <= cnt + 1'b1;
                            end
                        end else if (cnt != '0) begin
                            frame_err <= 1'b1;
                            cnt       <= '0;
                        end
                    WAIT_STAT, SHIFT_STAT:
                        if (!selSync) begin
                            shStat <= statNext;
                            if (cnt == 7'(SIZESRSTAT - 1)) begin
                                stat_reg   <= statNext;
                                stat_valid <= 1'b1;
                                cnt        <= '0;
                                state      <= DONE;
                            end else begin
                                cnt   <= cnt + 1'b1;
                                state <= SHIFT_STAT;
                            end
                        end else begin
                            // Premature SEL=1 aborts the static word but opens a new dynamic word
                            frame_err <= 1'b1;
                            shDyn     <= dynNext;
                            cnt       <= 7'd1;
                            state     <= SHIFT_DYN;
                        end
                    default:
                        if (selSync) begin
                            shDyn <= dynNext;
                            cnt   <= 7'd1;
                            state <= SHIFT_DYN;
                        end
                endcase
            end else if (toRun && toCnt == TW'(TIMEOUT_CYCLES - 1)) begin
                frame_err <= 1'b1;
                cnt       <= '0;
                state     <= SHIFT_DYN;
            end
        end
    end
endmodule

// File: tb/tb_asic_sr_receiver.sv
// tb_asic_sr_receiver: drives whole and broken serial frames, compares published
// words against the frames the bench itself sent.
module tb_asic_sr_receiver;
    import asic_bridge_pkg::*;

    localparam int T    = 4096;
    localparam int SYNC = 2;

    logic        CLK = 1'b0, RST_N = 1'b0, SCLK_in = 1'b0, SEL_in = 1'b0, MOSI_in = 1'b0;
    logic [15:0] dyn_reg;
    logic [87:0] stat_reg;
    logic        dyn_valid, stat_valid, frame_err, busy;

    int nCmp = 0, nErr = 0;
    int cyc = 0, lastRise = 0;
    int pulseViol = 0, partialViol = 0;
    logic [15:0] dynSeen[$];
    logic [87:0] statSeen[$];
    logic        prevDv = 1'b0, prevSv = 1'b0, prevRst = 1'b0;
    logic [15:0] prevDyn = '0;
    logic [87:0] prevStat = '0;

    asic_sr_receiver #(.SIZESRDYN(16), .SIZESRSTAT(88), .SYNC_STAGES(SYNC), .TIMEOUT_CYCLES(T)) dut (
        .CLK(CLK), .RST_N(RST_N), .SCLK_in(SCLK_in), .SEL_in(SEL_in), .MOSI_in(MOSI_in),
        .dyn_reg(dyn_reg), .stat_reg(stat_reg), .dyn_valid(dyn_valid), .stat_valid(stat_valid),
        .frame_err(frame_err), .busy(busy)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    // Observe publications; registers may only move together with their valid pulse
    always @(negedge CLK) begin
        if (dyn_valid) dynSeen.push_back(dyn_reg);
        if (stat_valid) statSeen.push_back(stat_reg);
        if ((dyn_valid && prevDv) || (stat_valid && prevSv)) pulseViol <= pulseViol + 1;
        if (RST_N && prevRst && ((dyn_reg !== prevDyn && !dyn_valid) || (stat_reg !== prevStat && !stat_valid)))
            partialViol <= partialViol + 1;
        prevDv   <= dyn_valid;
        prevSv   <= stat_valid;
        prevRst  <= RST_N;
        prevDyn  <= dyn_reg;
        prevStat <= stat_reg;
    end

    function automatic int ph();
        return int'($urandom_range(3, 5));
    endfunction

    function automatic logic [87:0] rnd88();
        logic [95:0] t;
        t = {$urandom, $urandom, $urandom};
        return t[87:0];
    endfunction

    task automatic sendBit(input logic sel, input logic d, input int hi, input int lo);
        SEL_in  = sel;
        MOSI_in = d;
        @(negedge CLK);
        SCLK_in  = 1'b1;
        lastRise = cyc;
        repeat (hi) @(negedge CLK);
        SCLK_in = 1'b0;
        repeat (lo - 1) @(negedge CLK);
    endtask

    task automatic sendDyn(input logic [15:0] v, input int n);
        for (int i = 0; i < n; i++) sendBit(1'b1, v[15-i], ph(), ph());
    endtask

    task automatic sendStat(input logic [87:0] v, input int n);
        for (int i = 0; i < n; i++) sendBit(1'b0, v[87-i], ph(), ph());
    endtask

    task automatic settle();
        repeat (8) @(negedge CLK);
    endtask

    task automatic doReset();
        @(negedge CLK);
        RST_N = 1'b0;
        repeat (2) @(negedge CLK);
        RST_N = 1'b1;
        dynSeen.delete();
        statSeen.delete();
        @(negedge CLK);
    endtask

    task automatic test_reset();
        doReset();
        nCmp++;
        if ({dyn_reg, stat_reg, dyn_valid, stat_valid, frame_err, busy} !== '0) begin
            nErr++;
            $display("FAIL reset_outputs: got dyn=%h stat=%h dv=%b sv=%b err=%b busy=%b, want all 0",
                     dyn_reg, stat_reg, dyn_valid, stat_valid, frame_err, busy);
        end
    endtask

    task automatic test_basic();
        doReset();
        sendDyn(DYN_INIT, 16);
        nCmp++;
        if (busy !== 1'b1) begin nErr++; $display("FAIL basic_busy_wait: got %b want 1", busy); end
        sendStat(STAT_INIT, 88);
        settle();
        nCmp++;
        if (dynSeen.size() != 1 || dyn_reg !== DYN_INIT) begin
            nErr++; $display("FAIL basic_dyn: got %h (%0d pulses) want %h (1 pulse)", dyn_reg, dynSeen.size(), DYN_INIT);
        end
        nCmp++;
        if (statSeen.size() != 1 || stat_reg !== STAT_INIT) begin
            nErr++; $display("FAIL basic_stat: got %h (%0d pulses) want %h (1 pulse)", stat_reg, statSeen.size(), STAT_INIT);
        end
        nCmp++;
        if (frame_err !== 1'b0 || busy !== 1'b0) begin
            nErr++; $display("FAIL basic_flags: got err=%b busy=%b want 0/0", frame_err, busy);
        end
    endtask

    task automatic test_sel_drop();
        logic [15:0] d;
        logic [87:0] s;
        doReset();
        d = 16'($urandom);
        sendDyn(d, 10);
        sendBit(1'b0, 1'b1, ph(), ph());
        settle();
        nCmp++;
        if (frame_err !== 1'b1 || dynSeen.size() != 0 || dyn_reg !== 16'h0) begin
            nErr++; $display("FAIL seldrop_err: got err=%b pulses=%0d dyn=%h want 1/0/0000", frame_err, dynSeen.size(), dyn_reg);
        end
        d = 16'($urandom);
        s = rnd88();
        sendDyn(d, 16);
        sendStat(s, 88);
        settle();
        nCmp++;
        if (dyn_reg !== d || stat_reg !== s || dynSeen.size() != 1 || statSeen.size() != 1) begin
            nErr++; $display("FAIL seldrop_recover: got dyn=%h stat=%h want dyn=%h stat=%h", dyn_reg, stat_reg, d, s);
        end
    endtask

    task automatic test_timeout();
        logic [15:0] d;
        logic        found;
        int          delta;
        doReset();
        d = 16'($urandom);
        sendDyn(d, 16);
        sendStat(rnd88(), 40);
        found = 1'b0;
        delta = 0;
        for (int k = 0; k < T + 100 && !found; k++) begin
            @(negedge CLK);
            if (frame_err) begin found = 1'b1; delta = cyc - lastRise; end
        end
        nCmp++;
        if (!found || delta != T + SYNC + 1) begin
            nErr++; $display("FAIL timeout_latency: got found=%b cycles=%0d want 1/%0d", found, delta, T + SYNC + 1);
        end
        nCmp++;
        if (stat_reg !== 88'h0 || statSeen.size() != 0 || dyn_reg !== d || busy !== 1'b0) begin
            nErr++; $display("FAIL timeout_state: got stat=%h dyn=%h busy=%b want stat=0 dyn=%h busy=0", stat_reg, dyn_reg, busy, d);
        end
    endtask

    task automatic test_reset_mid();
        logic [15:0] d;
        logic [87:0] s;
        doReset();
        sendDyn(16'($urandom) | 16'h1, 16);
        sendStat(rnd88(), 50);
        RST_N = 1'b0;
        @(negedge CLK);
        nCmp++;
        if ({dyn_reg, stat_reg, dyn_valid, stat_valid, frame_err, busy} !== '0) begin
            nErr++; $display("FAIL resetmid_outputs: got dyn=%h busy=%b err=%b want all 0", dyn_reg, busy, frame_err);
        end
        RST_N = 1'b1;
        dynSeen.delete();
        statSeen.delete();
        @(negedge CLK);
        d = 16'($urandom);
        s = rnd88();
        sendDyn(d, 16);
        sendStat(s, 88);
        settle();
        nCmp++;
        if (dyn_reg !== d || stat_reg !== s || frame_err !== 1'b0) begin
            nErr++; $display("FAIL resetmid_reload: got dyn=%h stat=%h err=%b want %h %h 0", dyn_reg, stat_reg, frame_err, d, s);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] dExp[2];
        logic [87:0] sExp[2];
        dExp = '{16'h0001, 16'h8000};
        sExp = '{{88{1'b1}}, 88'h0};
        doReset();
        for (int f = 0; f < 2; f++) begin
            sendDyn(dExp[f], 16);
            sendStat(sExp[f], 88);
        end
        for (int i = 0; i < 5; i++) sendBit(1'b0, 1'($urandom), ph(), ph());
        settle();
        nCmp++;
        if (dynSeen.size() != 2 || statSeen.size() != 2) begin
            nErr++; $display("FAIL b2b_pulses: got dyn=%0d stat=%0d pulses want 2/2", dynSeen.size(), statSeen.size());
        end else begin
            for (int f = 0; f < 2; f++) begin
                nCmp++;
                if (dynSeen[f] !== dExp[f] || statSeen[f] !== sExp[f]) begin
                    nErr++; $display("FAIL b2b_frame%0d: got %h/%h want %h/%h", f, dynSeen[f], statSeen[f], dExp[f], sExp[f]);
                end
            end
        end
        nCmp++;
        if (frame_err !== 1'b0 || busy !== 1'b0) begin
            nErr++; $display("FAIL b2b_done_idle: got err=%b busy=%b want 0/0", frame_err, busy);
        end
    endtask

    task automatic test_min_phase();
        logic [87:0] s;
        doReset();
        s = rnd88();
        for (int i = 0; i < 16; i++) sendBit(1'b1, ~i[0], 3, 3);
        for (int i = 0; i < 88; i++) sendBit(1'b0, s[87-i], 3, 3);
        settle();
        nCmp++;
        if (dyn_reg !== 16'hAAAA || stat_reg !== s || frame_err !== 1'b0) begin
            nErr++; $display("FAIL minphase: got dyn=%h stat=%h err=%b want AAAA %h 0", dyn_reg, stat_reg, frame_err, s);
        end
    endtask

    task automatic test_random_frames();
        logic [15:0] d;
        logic [87:0] s;
        doReset();
        for (int f = 0; f < 4; f++) begin
            d = 16'($urandom);
            s = rnd88();
            sendDyn(d, 16);
            sendStat(s, 88);
            settle();
            nCmp++;
            if (dynSeen.size() != f + 1 || statSeen.size() != f + 1 || dynSeen[f] !== d || statSeen[f] !== s) begin
                nErr++; $display("FAIL random_frame%0d: got dyn=%h stat=%h want %h %h", f, dyn_reg, stat_reg, d, s);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_sel_drop();
        test_timeout();
        test_reset_mid();
        test_back_to_back();
        test_min_phase();
        test_random_frames();
        nCmp++;
        if (pulseViol != 0 || partialViol != 0) begin
            nErr++; $display("FAIL publish_rules: got %0d long pulses, %0d unannounced updates, want 0/0", pulseViol, partialViol);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
        $finish;
    end
endmodule
